isp_stream_gen: RTL and testbench

Frame timing generator sitting directly downstream of the ISP input FIFO. It pulls 16-bit raw pixels from the FIFO read port and emits them as a vsync/hsync/de video stream for the first ISP pipeline stage. Frame geometry and blanking are programmable per frame. FIFO underflow inserts de-low gaps and never drops or duplicates pixels.

---
 rtl/isp_itf_pkg.sv | 17 +
 rtl/isp_blank_cnt.sv | 37 +++
 rtl/isp_stream_gen.sv | 219 +++++++++++++++++++++
 tb/tb_isp_stream_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_itf_pkg.sv
// Shared definitions for the ISP input-side stream blocks.
// Holds the default pixel / counter widths and the frame timing state encoding
// used by isp_stream_gen.
package isp_itf_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VB_PRE  = 3'd1,
    ST_LINE    = 3'd2,
    ST_HB      = 3'd3,
    ST_VB_POST = 3'd4
  } state_t;

endpackage

// File: rtl/isp_blank_cnt.sv
// Loadable down-counter with a zero flag, shared by all blanking intervals of
// isp_stream_gen. It saturates at zero, so an idle counter just sits there.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : load load_val this cycle (has priority over dec)
//   load_val    : value to load
//   dec         : decrement by one when not already zero
//   zero        : counter currently holds zero
module isp_blank_cnt #(
  parameter int CNT_WIDTH = isp_itf_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_r;

  // Counter register: load, saturating decrement, or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/isp_stream_gen.sv
// Frame timing generator between the ISP input FIFO and the first pipeline
// stage. Pops pixels from a show-ahead FIFO and emits a vsync/hsync/de stream
// with programmable geometry and blanking. FIFO underflow only stretches the
// line (de gaps); pixels are never dropped or duplicated.
//   clk, rst_n                 : clock, synchronous active-low reset
//   start                      : frame start pulse, honoured only when idle
//   frame_width/frame_height   : active pixels per line / lines per frame
//   hblank / vblank            : idle cycles between lines / around the frame
//   fifo_rd_data, fifo_empty_n : FIFO head word and non-empty flag
//   fifo_rd_en                 : FIFO pop (combinational)
//   out_vsync/out_hsync/out_de/out_data : registered video stream
//   busy                       : a frame is in progress
//   frame_done                 : pulse in the last cycle of the frame
//   cfg_err                    : pulse after a start with zero width/height
module isp_stream_gen #(
  parameter int DATA_WIDTH = isp_itf_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = isp_itf_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  frame_width,
  input  logic [CNT_WIDTH-1:0]  frame_height,
  input  logic [CNT_WIDTH-1:0]  hblank,
  input  logic [CNT_WIDTH-1:0]  vblank,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty_n,
  output logic                  fifo_rd_en,
  output logic                  out_vsync,
  output logic                  out_hsync,
  output logic                  out_de,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
);

  import isp_itf_pkg::*;

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t state_r, state_s;

  logic [CNT_WIDTH-1:0]  width_r, height_r, hblank_r, vblank_r;
  logic [CNT_WIDTH-1:0]  pix_cnt_r, line_cnt_r;
  logic [CNT_WIDTH-1:0]  hb_len_m1_s, blank_val_s;
  logic                  bad_cfg_s, accept_s, pop_s, last_pix_s, last_line_s;
  logic                  blank_load_s, blank_dec_s, blank_zero_s, frame_done_s;
  logic                  out_vsync_r, out_hsync_r, out_de_r, cfg_err_r;
  logic [DATA_WIDTH-1:0] out_data_r;

  assign bad_cfg_s   = (frame_width == CNT_ZERO) || (frame_height == CNT_ZERO);
  assign last_pix_s  = (pix_cnt_r == (width_r - CNT_ONE));
  assign last_line_s = (line_cnt_r == (height_r - CNT_ONE));
  // A zero hblank still costs one HB cycle so lines never abut.
  assign hb_len_m1_s = (hblank_r == CNT_ZERO) ? CNT_ZERO : (hblank_r - CNT_ONE);

  // One blanking counter serves VB_PRE, HB and VB_POST in turn.
  isp_blank_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_blank_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (blank_load_s),
    .load_val (blank_val_s),
    .dec      (blank_dec_s),
    .zero     (blank_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_VB_PRE;
        else          state_s = ST_IDLE;
      end
      ST_VB_PRE: begin
        if (blank_zero_s) state_s = ST_LINE;
        else              state_s = ST_VB_PRE;
      end
      ST_LINE: begin
        if (pop_s && last_pix_s) begin
          if (!last_line_s)            state_s = ST_HB;
          else if (vblank_r == CNT_ZERO) state_s = ST_IDLE;
          else                         state_s = ST_VB_POST;
        end else begin
          state_s = ST_LINE;
        end
      end
      ST_HB: begin
        if (blank_zero_s) state_s = ST_LINE;
        else              state_s = ST_HB;
      end
      ST_VB_POST: begin
        if (blank_zero_s) state_s = ST_IDLE;
        else              state_s = ST_VB_POST;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: pop, blank counter control, frame_done.
  // The counter is loaded with (cycles - 1) for HB/VB_POST because the state
  // is already entered on the loading edge; VB_PRE gets vblank itself, which
  // gives the extra VB_PRE->LINE cycle.
  always_comb begin
    accept_s     = 1'b0;
    pop_s        = 1'b0;
    frame_done_s = 1'b0;
    blank_load_s = 1'b0;
    blank_dec_s  = 1'b0;
    blank_val_s  = CNT_ZERO;
    case (state_r)
      ST_IDLE: begin
        accept_s     = start & ~bad_cfg_s;
        blank_load_s = accept_s;
        blank_val_s  = vblank;
      end
      ST_VB_PRE, ST_HB: begin
        blank_dec_s = ~blank_zero_s;
      end
      ST_LINE: begin
        pop_s = fifo_empty_n;
        if (pop_s && last_pix_s && last_line_s) begin
          blank_load_s = 1'b1;
          blank_val_s  = vblank_r - CNT_ONE;
          // No trailing blank: this last pop is the final cycle of the frame.
          frame_done_s = (vblank_r == CNT_ZERO);
        end else if (pop_s && last_pix_s) begin
          blank_load_s = 1'b1;
          blank_val_s  = hb_len_m1_s;
        end else begin
          blank_load_s = 1'b0;
        end
      end
      ST_VB_POST: begin
        blank_dec_s  = ~blank_zero_s;
        frame_done_s = blank_zero_s;
      end
      default: begin
        blank_load_s = 1'b0;
      end
    endcase
  end

  // Shadow copy of the frame configuration, captured on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_r  <= CNT_ZERO;
      height_r <= CNT_ZERO;
      hblank_r <= CNT_ZERO;
      vblank_r <= CNT_ZERO;
    end else if (accept_s) begin
      width_r  <= frame_width;
      height_r <= frame_height;
      hblank_r <= hblank;
      vblank_r <= vblank;
    end
  end

  // Pixel and line position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_r  <= CNT_ZERO;
      line_cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      pix_cnt_r  <= CNT_ZERO;
      line_cnt_r <= CNT_ZERO;
    end else begin
      if (pop_s) begin
        pix_cnt_r <= last_pix_s ? CNT_ZERO : (pix_cnt_r + CNT_ONE);
      end
      if ((state_r == ST_HB) && blank_zero_s) begin
        line_cnt_r <= line_cnt_r + CNT_ONE;
      end
    end
  end

  // Registered video stream and configuration error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_de_r    <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_hsync_r <= 1'b0;
      out_vsync_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      out_de_r    <= pop_s;
      if (pop_s) begin
        out_data_r <= fifo_rd_data;
      end
      out_hsync_r <= (state_r == ST_LINE);
      out_vsync_r <= (state_r == ST_LINE) || (state_r == ST_HB);
      cfg_err_r   <= (state_r == ST_IDLE) & start & bad_cfg_s;
    end
  end

  assign fifo_rd_en = pop_s;
  assign busy       = (state_r != ST_IDLE);
  assign frame_done = frame_done_s;
  assign out_de     = out_de_r;
  assign out_data   = out_data_r;
  assign out_hsync  = out_hsync_r;
  assign out_vsync  = out_vsync_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_isp_stream_gen.sv
// Directed self-checking bench for isp_stream_gen. Observation index k counts
// clock edges after the start edge (k=1 is the cycle right after start).
// Per-cycle outputs are collected into bit masks (bit k) and compared against
// hand-derived masks.
module tb_isp_stream_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] frame_width, frame_height, hblank, vblank;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty_n;
  logic        fifo_rd_en;
  logic        out_vsync, out_hsync, out_de;
  logic [15:0] out_data;
  logic        busy, frame_done, cfg_err;

  isp_stream_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .hblank       (hblank),
    .vblank       (vblank),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty_n (fifo_empty_n),
    .fifo_rd_en   (fifo_rd_en),
    .out_vsync    (out_vsync),
    .out_hsync    (out_hsync),
    .out_de       (out_de),
    .out_data     (out_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_check = 0;

  // FIFO model: 64 words, show-ahead, optional stall window in k.
  logic [15:0] pix_mem [0:63];
  int          rd_idx;
  int          cur_k;
  int          stall_lo = 1000;
  int          stall_hi = 0;

  // Stimulus events inside a run (k values, 0 = none).
  int          restart_at  = 0;
  int          restart2_at = 0;
  int          rst_at      = 0;
  logic [12:0] nxt_w, nxt_h, nxt_hb, nxt_vb;

  // Observations of the current run.
  logic [63:0] obs_de, obs_hs, obs_vs, obs_rd, obs_busy, obs_fd, obs_cfg;
  logic [15:0] obs_data [0:63];
  logic [15:0] got_data [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic drive_fifo();
    fifo_empty_n = !((cur_k >= stall_lo) && (cur_k <= stall_hi));
    fifo_rd_data = (rd_idx < 64) ? pix_mem[rd_idx] : 16'h0000;
  endtask

  task automatic load_fifo(input logic [15:0] base);
    for (int i = 0; i < 64; i++) pix_mem[i] = base + i[15:0];
    rd_idx = 0;
    drive_fifo();
    #1;
  endtask

  task automatic tick();
    logic pop;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop === 1'b1) rd_idx = rd_idx + 1;
    cur_k = cur_k + 1;
    drive_fifo();
    #1;
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb);
    frame_width  = w[12:0];
    frame_height = h[12:0];
    hblank       = hb[12:0];
    vblank       = vb[12:0];
  endtask

  // Caller raises start (if wanted) before calling; it is dropped after k=1.
  task automatic run_frame(input int ncyc);
    obs_de = '0; obs_hs = '0; obs_vs = '0; obs_rd = '0;
    obs_busy = '0; obs_fd = '0; obs_cfg = '0;
    got_data.delete();
    cur_k = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      obs_de[k]   = out_de;
      obs_hs[k]   = out_hsync;
      obs_vs[k]   = out_vsync;
      obs_rd[k]   = fifo_rd_en;
      obs_busy[k] = busy;
      obs_fd[k]   = frame_done;
      obs_cfg[k]  = cfg_err;
      obs_data[k] = out_data;
      if (out_de === 1'b1) got_data.push_back(out_data);
      start = 1'b0;
      rst_n = 1'b1;
      if (k == restart_at || k == restart2_at) begin
        start = 1'b1;
        set_cfg(int'(nxt_w), int'(nxt_h), int'(nxt_hb), int'(nxt_vb));
      end
      if (k == rst_at) rst_n = 1'b0;
    end
    stall_lo = 1000;
    restart_at = 0;
    restart2_at = 0;
    rst_at = 0;
  endtask

  task automatic chk_masks(input string t, input logic [63:0] de, input logic [63:0] hs,
                           input logic [63:0] vs, input logic [63:0] rd,
                           input logic [63:0] bz, input logic [63:0] fd);
    chk({t, "_de"},    obs_de,   de);
    chk({t, "_hsync"}, obs_hs,   hs);
    chk({t, "_vsync"}, obs_vs,   vs);
    chk({t, "_rd_en"}, obs_rd,   rd);
    chk({t, "_busy"},  obs_busy, bz);
    chk({t, "_done"},  obs_fd,   fd);
  endtask

  task automatic chk_data(input string t, input int n, input logic [15:0] base);
    chk({t, "_npix"}, 64'(got_data.size()), 64'(n));
    chk({t, "_pops"}, 64'(rd_idx), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_data.size()) chk({t, "_pix"}, 64'(got_data[i]), 64'(base + i[15:0]));
      else                     chk({t, "_pix_missing"}, 64'(i), 64'(n));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_cfg(4, 2, 2, 3);
    cur_k = 0;
    load_fifo(16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_video", {61'd0, out_vsync, out_hsync, out_de}, 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    chk("rst_ctl",   {60'd0, busy, frame_done, cfg_err, fifo_rd_en}, 64'd0);

    // Basic frame W=4 H=2 hb=2 vb=3, pixels 0..7.
    load_fifo(16'h0000);
    set_cfg(4, 2, 2, 3);
    start = 1'b1;
    run_frame(20);
    chk_masks("basic", 64'hF3C0, 64'hF3C0, 64'hFFC0, 64'h79E0, 64'h3FFFE, 64'h20000);
    chk_data("basic", 8, 16'h0000);

    // Same frame, FIFO empty for k=6..8 inside line 0.
    load_fifo(16'h0000);
    stall_lo = 6;
    stall_hi = 8;
    start = 1'b1;
    run_frame(22);
    chk_masks("underflow", 64'h79C40, 64'h79FC0, 64'h7FFC0, 64'h3CE20, 64'h1FFFFE, 64'h100000);
    chk_data("underflow", 8, 16'h0000);

    // Zero width, then zero height: cfg_err pulse, nothing else.
    load_fifo(16'h1100);
    set_cfg(0, 2, 2, 3);
    start = 1'b1;
    run_frame(4);
    chk("w0_cfg_err", obs_cfg, 64'h2);
    chk("w0_busy", obs_busy, 64'h0);
    chk("w0_rd_en", obs_rd, 64'h0);
    set_cfg(3, 0, 2, 3);
    start = 1'b1;
    run_frame(4);
    chk("h0_cfg_err", obs_cfg, 64'h2);
    chk("h0_busy", obs_busy, 64'h0);
    chk("h0_pops", 64'(rd_idx), 64'd0);

    // No blanking: W=2 H=3 hb=0 vb=0.
    load_fifo(16'h5A00);
    set_cfg(2, 3, 0, 0);
    start = 1'b1;
    run_frame(12);
    chk_masks("noblank", 64'h6D8, 64'h6D8, 64'h7F8, 64'h36C, 64'h3FE, 64'h200);
    chk_data("noblank", 6, 16'h5A00);
    chk("noblank_cfg_err", obs_cfg, 64'h0);

    // Restart mid-frame and together with frame_done: both ignored.
    load_fifo(16'h7100);
    set_cfg(3, 2, 1, 1);
    nxt_w = 13'd1; nxt_h = 13'd1; nxt_hb = 13'd0; nxt_vb = 13'd2;
    restart_at  = 4;
    restart2_at = 10;
    start = 1'b1;
    run_frame(12);
    chk_masks("restart_a", 64'h770, 64'h770, 64'h7F0, 64'h3B8, 64'h7FE, 64'h400);
    chk_data("restart_a", 6, 16'h7100);
    // Next start picks up the configuration now on the inputs.
    load_fifo(16'h7200);
    start = 1'b1;
    run_frame(8);
    chk_masks("restart_b", 64'h20, 64'h20, 64'h20, 64'h10, 64'h7E, 64'h40);
    chk_data("restart_b", 1, 16'h7200);

    // Reset mid-line 0 (rst_n low for the cycle before edge k=8).
    load_fifo(16'hC000);
    set_cfg(4, 2, 2, 3);
    rst_at = 7;
    start = 1'b1;
    run_frame(10);
    chk_masks("midrst", 64'hC0, 64'hC0, 64'hC0, 64'hE0, 64'hFE, 64'h0);
    chk("midrst_data_before", 64'(obs_data[7]), 64'hC001);
    chk("midrst_data_after", 64'(obs_data[8]), 64'h0);
    chk("midrst_pops", 64'(rd_idx), 64'd3);
    // Clean frame after the reset.
    load_fifo(16'h3300);
    start = 1'b1;
    run_frame(20);
    chk_masks("postrst", 64'hF3C0, 64'hF3C0, 64'hFFC0, 64'h79E0, 64'h3FFFE, 64'h20000);
    chk_data("postrst", 8, 16'h3300);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
